// File: rtl/wb_interconnect_n.sv
// Single-master Wishbone interconnect fanning out to NUM_SLAVES address windows,
// with a per-access ack timeout and sticky error reporting.
module wb_interconnect_n #(
   parameter int NUM_SLAVES = 4,
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int WIN_BITS   = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_W-1:0]            wb_adr_i,
   input  logic [DATA_W-1:0]            wb_dat_i,
   output logic [DATA_W-1:0]            wb_dat_o,
   input  logic                         wb_cyc_i,
   input  logic                         wb_stb_i,
   input  logic                         wb_we_i,
   output logic                         wb_ack_o,
   output logic [NUM_SLAVES*ADDR_W-1:0] s_adr_o,
   output logic [NUM_SLAVES*DATA_W-1:0] s_dat_o,
   input  logic [NUM_SLAVES*DATA_W-1:0] s_dat_i,
   output logic [NUM_SLAVES-1:0]        s_cyc_o,
   output logic [NUM_SLAVES-1:0]        s_stb_o,
   output logic [NUM_SLAVES-1:0]        s_we_o,
   input  logic [NUM_SLAVES-1:0]        s_ack_i,
   input  logic                         clr_err,
   output logic                         err_unmapped,
   output logic                         err_timeout,
   output logic [ADDR_W-1:0]            err_adr
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_W-1:0]       adr_q, adr_d;
   logic [DATA_W-1:0]       dat_q, dat_d;
   logic                    we_q, we_d;
   logic [NUM_SLAVES-1:0]   sel_q, sel_d;
   logic [15:0]             cnt_q, cnt_d;
   logic                    ack_q, ack_d;
   logic [DATA_W-1:0]       rdat_q, rdat_d;
   logic                    err_unmapped_q, err_unmapped_d;
   logic                    err_timeout_q, err_timeout_d;
   logic [ADDR_W-1:0]       err_adr_q, err_adr_d;

   logic [31:0]             req_idx;
   logic [NUM_SLAVES-1:0]   req_sel;
   logic                    busy;
   logic                    slave_ack;
   logic [DATA_W-1:0]       slave_rdat;

   // Full upper field is compared, so indices past NUM_SLAVES select nothing.
   assign req_idx = 32'(wb_adr_i[ADDR_W-1:WIN_BITS]);
   assign busy    = (state_q == BUSY);

   generate
      for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
         logic act;
         assign req_sel[gi] = (req_idx == 32'(gi));
         assign act         = busy & sel_q[gi];
         assign s_cyc_o[gi] = act;
         assign s_stb_o[gi] = act;
         assign s_we_o[gi]  = act & we_q;
         assign s_adr_o[gi*ADDR_W +: ADDR_W] = act ? adr_q : '0;
         assign s_dat_o[gi*DATA_W +: DATA_W] = act ? dat_q : '0;
      end
   endgenerate

   assign slave_ack = |(s_ack_i & sel_q);

   always_comb begin
      slave_rdat = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (sel_q[k]) slave_rdat = slave_rdat | s_dat_i[k*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_d        = state_q;
      adr_d          = adr_q;
      dat_d          = dat_q;
      we_d           = we_q;
      sel_d          = sel_q;
      cnt_d          = cnt_q;
      ack_d          = 1'b0;
      rdat_d         = rdat_q;
      err_unmapped_d = err_unmapped_q;
      err_timeout_d  = err_timeout_q;
      err_adr_d      = err_adr_q;

      // Clear first so an error event later in this block overrides it.
      if (clr_err) begin
         err_unmapped_d = 1'b0;
         err_timeout_d  = 1'b0;
         err_adr_d      = '0;
      end

      case (state_q)
         IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               adr_d = wb_adr_i;
               dat_d = wb_dat_i;
               we_d  = wb_we_i;
               sel_d = req_sel;
               cnt_d = '0;
               if (|req_sel) begin
                  state_d = BUSY;
               end else begin
                  state_d        = DONE;
                  ack_d          = 1'b1;
                  rdat_d         = '1;
                  err_unmapped_d = 1'b1;
                  err_adr_d      = wb_adr_i;
               end
            end
         end
         BUSY: begin
            if (!wb_cyc_i) begin
               state_d = IDLE;
            end else if (slave_ack) begin
               state_d = DONE;
               ack_d   = 1'b1;
               rdat_d  = slave_rdat;
            end else if (cnt_q == 16'(TIMEOUT - 1)) begin
               state_d       = DONE;
               ack_d         = 1'b1;
               rdat_d        = '1;
               err_timeout_d = 1'b1;
               err_adr_d     = adr_q;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         DONE: begin
            if (!wb_stb_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         adr_q          <= '0;
         dat_q          <= '0;
         we_q           <= 1'b0;
         sel_q          <= '0;
         cnt_q          <= '0;
         ack_q          <= 1'b0;
         rdat_q         <= '0;
         err_unmapped_q <= 1'b0;
         err_timeout_q  <= 1'b0;
         err_adr_q      <= '0;
      end else begin
         state_q        <= state_d;
         adr_q          <= adr_d;
         dat_q          <= dat_d;
         we_q           <= we_d;
         sel_q          <= sel_d;
         cnt_q          <= cnt_d;
         ack_q          <= ack_d;
         rdat_q         <= rdat_d;
         err_unmapped_q <= err_unmapped_d;
         err_timeout_q  <= err_timeout_d;
         err_adr_q      <= err_adr_d;
      end
   end

   assign wb_ack_o     = ack_q;
   assign wb_dat_o     = rdat_q;
   assign err_unmapped = err_unmapped_q;
   assign err_timeout  = err_timeout_q;
   assign err_adr      = err_adr_q;

endmodule

// File: tb/tb_wb_interconnect_n.sv
// Directed bench for wb_interconnect_n: 4 slaves, 16-byte windows, TIMEOUT=8.
module tb_wb_interconnect_n;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  wb_adr_i, wb_dat_i, wb_dat_o;
   logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o;
   logic [31:0] s_adr_o, s_dat_o, s_dat_i;
   logic [3:0]  s_cyc_o, s_stb_o, s_we_o, s_ack_i;
   logic        clr_err, err_unmapped, err_timeout;
   logic [7:0]  err_adr;

   int checks = 0;
   int errors = 0;
   int stb_cycles;

   always #5 clk = ~clk;

   wb_interconnect_n #(
      .NUM_SLAVES(4), .ADDR_W(8), .DATA_W(8), .WIN_BITS(4), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_ack_i(s_ack_i),
      .clr_err(clr_err), .err_unmapped(err_unmapped), .err_timeout(err_timeout),
      .err_adr(err_adr)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; wb_adr_i = '0; wb_dat_i = '0; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
      s_dat_i = '0; s_ack_i = '0; clr_err = 0;
      step(); step();
      chk("rst_ack", 32'(wb_ack_o), 0);
      chk("rst_dat", 32'(wb_dat_o), 0);
      chk("rst_stb", 32'(s_stb_o), 0);
      chk("rst_err", {30'd0, err_unmapped, err_timeout}, 0);
      rst = 1'b0;
      step();

      // Read 0x12, slave 1 answers 0xA5 on the third strobe cycle
      wb_adr_i = 8'h12; wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0;
      step();
      chk("rd_stb", 32'(s_stb_o), 32'h2);
      chk("rd_cyc", 32'(s_cyc_o), 32'h2);
      chk("rd_adr", s_adr_o, 32'h0000_1200);
      chk("rd_we", 32'(s_we_o), 0);
      s_ack_i = 4'b1000; s_dat_i = 32'h7700_0000;
      step();
      chk("foreign_ack", 32'(wb_ack_o), 0);
      chk("rd_stb2", 32'(s_stb_o), 32'h2);
      s_ack_i = '0;
      step();
      chk("rd_wait_ack", 32'(wb_ack_o), 0);
      s_ack_i = 4'b0010; s_dat_i = 32'h0000_A500;
      step();
      chk("rd_ack", 32'(wb_ack_o), 1);
      chk("rd_dat", 32'(wb_dat_o), 32'hA5);
      chk("rd_stb_off", 32'(s_stb_o), 0);
      chk("rd_noerr", {30'd0, err_unmapped, err_timeout}, 0);
      s_ack_i = '0; wb_cyc_i = 0; wb_stb_i = 0;
      step();
      chk("rd_ack_pulse", 32'(wb_ack_o), 0);

      // Unmapped write to 0x45
      wb_adr_i = 8'h45; wb_dat_i = 8'h3C; wb_we_i = 1; wb_cyc_i = 1; wb_stb_i = 1;
      step();
      chk("um_ack", 32'(wb_ack_o), 1);
      chk("um_dat", 32'(wb_dat_o), 32'hFF);
      chk("um_stb", 32'(s_stb_o), 0);
      chk("um_flag", 32'(err_unmapped), 1);
      chk("um_adr", 32'(err_adr), 32'h45);
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
      step();
      chk("um_ack_pulse", 32'(wb_ack_o), 0);
      clr_err = 1;
      step();
      clr_err = 0;
      chk("um_clr_flag", 32'(err_unmapped), 0);
      chk("um_clr_adr", 32'(err_adr), 0);

      // Timeout on silent slave 2
      wb_adr_i = 8'h20; wb_cyc_i = 1; wb_stb_i = 1;
      stb_cycles = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (wb_ack_o) break;
         if (s_stb_o == 4'b0100) stb_cycles++;
      end
      chk("to_stb_cycles", 32'(stb_cycles), 8);
      chk("to_ack", 32'(wb_ack_o), 1);
      chk("to_dat", 32'(wb_dat_o), 32'hFF);
      chk("to_flag", 32'(err_timeout), 1);
      chk("to_adr", 32'(err_adr), 32'h20);
      chk("to_stb_off", 32'(s_stb_o), 0);
      wb_cyc_i = 0; wb_stb_i = 0;
      step();
      clr_err = 1;
      step();
      clr_err = 0;
      chk("to_clr_flag", 32'(err_timeout), 0);
      chk("to_clr_adr", 32'(err_adr), 0);

      // Slave 0 acks on the final timeout cycle
      wb_adr_i = 8'h05; wb_cyc_i = 1; wb_stb_i = 1;
      step();
      for (int i = 0; i < 7; i++) step();
      chk("late_pre_ack", 32'(wb_ack_o), 0);
      s_ack_i = 4'b0001; s_dat_i = 32'h0000_0011;
      step();
      chk("late_ack", 32'(wb_ack_o), 1);
      chk("late_dat", 32'(wb_dat_o), 32'h11);
      chk("late_noerr", 32'(err_timeout), 0);
      s_ack_i = '0; wb_cyc_i = 0; wb_stb_i = 0;
      step();

      // Master abort two cycles into BUSY
      wb_adr_i = 8'h30; wb_cyc_i = 1; wb_stb_i = 1;
      step();
      chk("ab_stb", 32'(s_stb_o), 32'h8);
      step();
      wb_cyc_i = 0; wb_stb_i = 0;
      step();
      chk("ab_stb_off", 32'(s_stb_o), 0);
      chk("ab_noack", 32'(wb_ack_o), 0);
      chk("ab_noerr", {30'd0, err_unmapped, err_timeout}, 0);
      step();
      chk("ab_noack2", 32'(wb_ack_o), 0);

      // Asynchronous reset mid-BUSY
      wb_adr_i = 8'h10; wb_cyc_i = 1; wb_stb_i = 1;
      step();
      chk("ar_stb", 32'(s_stb_o), 32'h2);
      #2 rst = 1'b1;
      #1;
      chk("ar_stb_off", 32'(s_stb_o), 0);
      chk("ar_cyc_off", 32'(s_cyc_o), 0);
      chk("ar_adr_off", s_adr_o, 0);
      chk("ar_dat", 32'(wb_dat_o), 0);
      wb_cyc_i = 0; wb_stb_i = 0;
      #2 rst = 1'b0;
      step();

      // Zero-wait read after reset, then stb held 5 cycles past ack
      wb_adr_i = 8'h12; wb_cyc_i = 1; wb_stb_i = 1;
      step();
      chk("zw_stb", 32'(s_stb_o), 32'h2);
      s_ack_i = 4'b0010; s_dat_i = 32'h0000_5A00;
      step();
      chk("zw_ack", 32'(wb_ack_o), 1);
      chk("zw_dat", 32'(wb_dat_o), 32'h5A);
      s_ack_i = '0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_stb", 32'(s_stb_o), 0);
         chk("hold_ack", 32'(wb_ack_o), 0);
      end
      wb_stb_i = 0;
      step();
      chk("hold_rel_stb", 32'(s_stb_o), 0);
      wb_stb_i = 1;
      step();
      chk("re_stb", 32'(s_stb_o), 32'h2);
      s_ack_i = 4'b0010; s_dat_i = 32'h0000_C300;
      step();
      chk("re_ack", 32'(wb_ack_o), 1);
      chk("re_dat", 32'(wb_dat_o), 32'hC3);
      s_ack_i = '0; wb_cyc_i = 0; wb_stb_i = 0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
